dma_axi_slave_mem: RTL and testbench
====================================

# dma_axi_slave_mem

AXI-style memory responder: the target end of the DMA engine's AXI master port. Accepts read-address/read-data and write-address/write-data/write-response transactions, including INCR bursts, and backs them with an internal word-addressed RAM. Serves as the source and destination memory for DMA transfers in simulation and small on-chip configurations. The read and write channels run as independent state machines.

## Interface

- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 64: data bus width in bits, a power of two ≥ 8. `NB = DATA_WIDTH/8` bytes per beat.
- `MEM_DEPTH`, 1024: number of `DATA_WIDTH` words in the RAM, a power of two.
- `BASE_ADDR`, 0: byte address of word 0. Must be NB-aligned.

Ports:

- `clk`  in  1  clock. One clock domain; all logic is on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `s_axi_awvalid` in 1, `s_axi_awready` out 1, `s_axi_awaddr` in ADDR_WIDTH, `s_axi_awlen` in 8: write address channel. Burst length is `awlen`+1.
- `s_axi_wvalid` in 1, `s_axi_wready` out 1, `s_axi_wdata` in DATA_WIDTH, `s_axi_wstrb` in NB, `s_axi_wlast` in 1: write data channel.
- `s_axi_bvalid` out 1, `s_axi_bready` in 1, `s_axi_bresp` out 2: write response channel.
- `s_axi_arvalid` in 1, `s_axi_arready` out 1, `s_axi_araddr` in ADDR_WIDTH, `s_axi_arlen` in 8: read address channel. Burst length is `arlen`+1.
- `s_axi_rvalid` out 1, `s_axi_rready` in 1, `s_axi_rdata` out DATA_WIDTH, `s_axi_rresp` out 2, `s_axi_rlast` out 1: read data channel.

## Operation

Address decode and response codes:

- Word index is `(addr - BASE_ADDR) >> log2(NB)`. The low log2(NB) address bits are ignored.
- A beat is in range when `addr >= BASE_ADDR` and the index is less than `MEM_DEPTH`.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- Burst address increments by NB per beat, computed modulo 2^ADDR_WIDTH. Range is checked on every beat.

Write FSM:

- **W_IDLE:** `awready`=1. On `awvalid & awready`, latch address and `awlen`, clear the beat counter and the error flag, and go to W_DATA.
- **W_DATA:** `wready`=1. On each `wvalid & wready`:
  - If the beat is in range, write the bytes whose `wstrb` bit is set. Bytes with a clear strobe keep their old value.
  - If the beat is out of range, discard it and set the error flag.
  - If `wlast` differs from (beat == `awlen`), set the error flag.
  - Increment the address. On the beat where the count equals `awlen`, go to W_RESP.
  - The burst always ends after exactly `awlen`+1 beats; `wlast` never ends it early.
- **W_RESP:** `bvalid`=1 and `bresp` = SLVERR if the error flag is set, else OKAY. On `bready`, go to W_IDLE.

Read FSM:

- **R_IDLE:** `arready`=1. On `arvalid & arready`, latch address and `arlen`, clear the beat counter, load `rdata`/`rresp` for beat 0, and go to R_DATA.
- **R_DATA:** `rvalid`=1 and `rlast` = (beat == `arlen`).
  - `rdata` holds RAM[index] when the beat is in range. Out-of-range beats return `rdata`=0 with `rresp` = SLVERR.
  - On `rvalid & rready`: if not the last beat, load the next beat; if the last beat, go to R_IDLE.
- `rdata`, `rresp` and `rlast` hold stable while `rvalid & !rready`.

Concurrency:

- Read and write FSMs are fully independent. Both may be active in the same cycle.
- A read loading a word on the same edge as a write to that word returns the old data. The RAM is read before the write takes effect.

## Timing

- All outputs are registered.
- Reset values: every ready/valid = 0, `bresp` = 0, `rresp` = 0, `rdata` = 0, `rlast` = 0. Both FSMs go to IDLE.
- `awready` and `arready` assert on the first cycle after `rst` deasserts.
- RAM contents are not reset.
- Read latency: AR handshake at edge N gives `rvalid` high in cycle N+1 with beat-0 data.
- Read throughput: one beat per cycle while `rready` is held high.
- After the `rlast` handshake at edge M, `arready` is high in cycle M+1.
- Write throughput: AW handshake at edge N gives `wready` high from cycle N+1, one beat per cycle.
- Write response: the final W handshake at edge M gives `bvalid` in cycle M+1. After the B handshake at edge K, `awready` is high in cycle K+1.
- `awready` is low from W_DATA until the B handshake completes. `arready` is low throughout R_DATA. No new address is accepted while a burst is in flight.
- `rst` asserted mid-burst aborts on the next edge: all outputs return to reset values and partially written data stays in RAM.
- A valid held with no ready is never dropped. A master-side valid de-asserting is tolerated; the FSM simply waits.

## Test plan

- **Single write/read:** AW addr 0x10, len 0; W data 0x1122334455667788, strb 0xFF, wlast=1. Expect B OKAY one cycle after the W handshake. Then AR 0x10, len 0. Expect `rdata` 0x1122334455667788, `rlast`=1, OKAY, with `rvalid` one cycle after AR.
- **Byte strobes:** write 0xFFFF…FF to word 3, then 0x00…00 to word 3 with strb 0x0F. Read word 3: expect 0xFFFFFFFF00000000.
- **Burst with backpressure:** write 4 beats (len 3) at 0x40 with values 1..4. Read len 3 with `rready` toggling 1,0,1,0. Expect 1,2,3,4 in order, `rdata` stable while stalled, `rlast` only on beat 4.
- **Error cases:**
  - Read at `BASE_ADDR + MEM_DEPTH*NB`: expect `rdata` 0 with SLVERR.
  - Write burst len 1 with `wlast`=1 on beat 0: expect 2 beats accepted and bresp SLVERR.
  - Write whose second beat crosses the top of memory: expect beat 1 discarded, SLVERR, and beat 0 stored.
- **Concurrency and reset:**
  - Issue a read and a write to the same word on the same edge: the read returns the old value.
  - Assert `rst` during the second beat of a 4-beat read: all outputs are 0 on the next cycle and `arready`=1 the cycle after `rst` drops.

Source files
------------

// File: rtl/dma_axi_slave_mem.sv
// dma_axi_slave_mem
//   AXI-style memory responder backing DMA transfers with an internal word-addressed RAM.
//   Read and write channels are independent FSMs; INCR bursts only.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   s_axi_aw*           : write address (awvalid/awready/awaddr/awlen)
//   s_axi_w*            : write data (wvalid/wready/wdata/wstrb/wlast)
//   s_axi_b*            : write response (bvalid/bready/bresp)
//   s_axi_ar*           : read address (arvalid/arready/araddr/arlen)
//   s_axi_r*            : read data (rvalid/rready/rdata/rresp/rlast)
// All outputs are registered.

module dma_axi_slave_mem #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  // write address
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  // write data
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  // write response
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  // read address
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  // read data
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int unsigned           NB      = DATA_WIDTH / 8;
  localparam int unsigned           OFFS    = $clog2(NB);
  localparam int unsigned           IDXW    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] NB_A    = ADDR_WIDTH'(NB);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
  typedef enum logic [0:0] {RIdle, RData} rstate_e;

  // RAM is intentionally not reset
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wstate_e               r_wstate, w_wstate_d;
  logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_d;
  logic [7:0]            r_wlen, w_wlen_d;
  logic [7:0]            r_wcnt, w_wcnt_d;
  logic                  r_werr, w_werr_d;
  logic                  r_awready, w_awready_d;
  logic                  r_wready, w_wready_d;
  logic                  r_bvalid, w_bvalid_d;
  logic [1:0]            r_bresp, w_bresp_d;
  logic                  w_mem_we;

  // Extra MSB of the difference is the borrow: set when the address is below BASE_ADDR.
  logic [ADDR_WIDTH:0]   w_wr_diff;
  logic [ADDR_WIDTH-1:0] w_wr_word;
  logic                  w_wr_inrange;
  logic [IDXW-1:0]       w_wr_idx;
  logic [DATA_WIDTH-1:0] w_wr_merged;

  assign w_wr_diff    = {1'b0, r_waddr} - {1'b0, BASE_ADDR};
  assign w_wr_word    = w_wr_diff[ADDR_WIDTH-1:0] >> OFFS;
  assign w_wr_inrange = !w_wr_diff[ADDR_WIDTH] && (w_wr_word < DEPTH_A);
  assign w_wr_idx     = w_wr_word[IDXW-1:0];

  // Byte-strobe merge with the current word contents
  always_comb begin
    w_wr_merged = r_mem[w_wr_idx];
    for (int unsigned b = 0; b < NB; b++) begin
      if (s_axi_wstrb[b]) begin
        w_wr_merged[b*8 +: 8] = s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_wstate_d = r_wstate;
    w_waddr_d  = r_waddr;
    w_wlen_d   = r_wlen;
    w_wcnt_d   = r_wcnt;
    w_werr_d   = r_werr;
    w_mem_we   = 1'b0;
    unique case (r_wstate)
      WIdle: begin
        if (s_axi_awvalid && r_awready) begin
          w_waddr_d  = s_axi_awaddr;
          w_wlen_d   = s_axi_awlen;
          w_wcnt_d   = 8'd0;
          w_werr_d   = 1'b0;
          w_wstate_d = WData;
        end
      end
      WData: begin
        if (s_axi_wvalid && r_wready) begin
          if (w_wr_inrange) begin
            w_mem_we = !rst;
          end else begin
            w_werr_d = 1'b1;
          end
          // wlast is only checked, never used to terminate the burst
          if (s_axi_wlast != (r_wcnt == r_wlen)) begin
            w_werr_d = 1'b1;
          end
          w_waddr_d = r_waddr + NB_A;
          w_wcnt_d  = r_wcnt + 8'd1;
          if (r_wcnt == r_wlen) begin
            w_wstate_d = WResp;
          end
        end
      end
      WResp: begin
        if (s_axi_bready && r_bvalid) begin
          w_wstate_d = WIdle;
        end
      end
      default: w_wstate_d = WIdle;
    endcase

    // Outputs registered from the next state
    w_awready_d = (w_wstate_d == WIdle);
    w_wready_d  = (w_wstate_d == WData);
    w_bvalid_d  = (w_wstate_d == WResp);
    w_bresp_d   = ((w_wstate_d == WResp) && w_werr_d) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= WIdle;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_d;
      r_waddr   <= w_waddr_d;
      r_wlen    <= w_wlen_d;
      r_wcnt    <= w_wcnt_d;
      r_werr    <= w_werr_d;
      r_awready <= w_awready_d;
      r_wready  <= w_wready_d;
      r_bvalid  <= w_bvalid_d;
      r_bresp   <= w_bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_wr_idx] <= w_wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rstate_e               r_rstate, w_rstate_d;
  logic [ADDR_WIDTH-1:0] r_raddr, w_raddr_d;
  logic [7:0]            r_rlen, w_rlen_d;
  logic [7:0]            r_rcnt, w_rcnt_d;
  logic                  r_arready, w_arready_d;
  logic                  r_rvalid, w_rvalid_d;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_d;
  logic [1:0]            r_rresp, w_rresp_d;
  logic                  r_rlast, w_rlast_d;
  logic                  w_rd_load;

  // Address of the beat to load: the new burst start in idle, else the following beat
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH:0]   w_rd_diff;
  logic [ADDR_WIDTH-1:0] w_rd_word;
  logic                  w_rd_inrange;
  logic [IDXW-1:0]       w_rd_idx;

  assign w_rd_addr    = (r_rstate == RIdle) ? s_axi_araddr : (r_raddr + NB_A);
  assign w_rd_diff    = {1'b0, w_rd_addr} - {1'b0, BASE_ADDR};
  assign w_rd_word    = w_rd_diff[ADDR_WIDTH-1:0] >> OFFS;
  assign w_rd_inrange = !w_rd_diff[ADDR_WIDTH] && (w_rd_word < DEPTH_A);
  assign w_rd_idx     = w_rd_word[IDXW-1:0];

  always_comb begin
    w_rstate_d = r_rstate;
    w_raddr_d  = r_raddr;
    w_rlen_d   = r_rlen;
    w_rcnt_d   = r_rcnt;
    w_rdata_d  = r_rdata;
    w_rresp_d  = r_rresp;
    w_rlast_d  = r_rlast;
    w_rd_load  = 1'b0;
    unique case (r_rstate)
      RIdle: begin
        if (s_axi_arvalid && r_arready) begin
          w_raddr_d  = w_rd_addr;
          w_rlen_d   = s_axi_arlen;
          w_rcnt_d   = 8'd0;
          w_rd_load  = 1'b1;
          w_rstate_d = RData;
        end
      end
      RData: begin
        if (r_rvalid && s_axi_rready) begin
          if (r_rcnt == r_rlen) begin
            w_rstate_d = RIdle;
          end else begin
            w_raddr_d = w_rd_addr;
            w_rcnt_d  = r_rcnt + 8'd1;
            w_rd_load = 1'b1;
          end
        end
      end
      default: w_rstate_d = RIdle;
    endcase

    // RAM is read here, before any same-edge write lands, so a colliding read sees old data
    if (w_rd_load) begin
      w_rdata_d = w_rd_inrange ? r_mem[w_rd_idx] : '0;
      w_rresp_d = w_rd_inrange ? RESP_OKAY : RESP_SLVERR;
      w_rlast_d = (w_rcnt_d == w_rlen_d);
    end else if (w_rstate_d == RIdle) begin
      w_rlast_d = 1'b0;
    end

    w_arready_d = (w_rstate_d == RIdle);
    w_rvalid_d  = (w_rstate_d == RData);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= RIdle;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_d;
      r_raddr   <= w_raddr_d;
      r_rlen    <= w_rlen_d;
      r_rcnt    <= w_rcnt_d;
      r_arready <= w_arready_d;
      r_rvalid  <= w_rvalid_d;
      r_rdata   <= w_rdata_d;
      r_rresp   <= w_rresp_d;
      r_rlast   <= w_rlast_d;
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;

endmodule

// File: tb/tb_dma_axi_slave_mem.sv
// Testbench for dma_axi_slave_mem: scoreboard of expected R beats and B responses.
module tb_dma_axi_slave_mem;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic        s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic        s_axi_rvalid, s_axi_rready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;

  dma_axi_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(1024), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t      exp_rq[$];
  beat_t      obs_rq[$];
  logic [1:0] exp_bq[$];
  logic [1:0] obs_bq[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         g_tmo    = 1'b0;

  function automatic beat_t mk(input logic [63:0] d, input logic [1:0] r, input logic l);
    mk = {d, r, l};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 50) begin step(); n++; end
    if (!s_axi_awready) g_tmo = 1'b1; else step();
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
    int n = 0;
    s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 50) begin step(); n++; end
    if (!s_axi_wready) g_tmo = 1'b1; else step();
    s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    s_axi_araddr = a; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 50) begin step(); n++; end
    if (!s_axi_arready) g_tmo = 1'b1; else step();
    s_axi_arvalid = 1'b0;
  endtask

  // Collects one B response into obs_bq; lat = cycles waited before bvalid was seen.
  task automatic recv_b(output int lat);
    int n = 0;
    s_axi_bready = 1'b1;
    while (!s_axi_bvalid && n < 50) begin step(); n++; end
    lat = n;
    if (!s_axi_bvalid) g_tmo = 1'b1;
    else begin obs_bq.push_back(s_axi_bresp); step(); end
    s_axi_bready = 1'b0;
  endtask

  // Collects n R beats into obs_rq with rready following pat (bit k%4 in cycle k).
  // unstable counts stalled cycles whose beat changed before being accepted.
  task automatic recv_r(input int n, input logic [3:0] pat, output int lat0, output int unstable);
    int    got = 0;
    int    cyc = 0;
    bit    stalled = 1'b0;
    beat_t snap = '0;
    beat_t cur;
    lat0 = -1; unstable = 0;
    while (got < n && cyc < 200) begin
      s_axi_rready = pat[cyc % 4];
      if (s_axi_rvalid) begin
        if (lat0 < 0) lat0 = cyc;
        cur = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
        if (stalled && cur !== snap) unstable++;
        if (s_axi_rready) begin obs_rq.push_back(cur); got++; stalled = 1'b0; end
        else begin snap = cur; stalled = 1'b1; end
      end
      step();
      cyc++;
    end
    s_axi_rready = 1'b0;
    if (got < n) g_tmo = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready, s_axi_rvalid,
         s_axi_rresp, s_axi_rlast} !== 10'b0)
      $display("FAIL reset_ctrl: got %b required 0", {s_axi_awready, s_axi_wready, s_axi_bvalid,
               s_axi_bresp, s_axi_arready, s_axi_rvalid, s_axi_rresp, s_axi_rlast});
    else n_pass++;
    n_checks++;
    if (s_axi_rdata !== 64'h0) $display("FAIL reset_rdata: got %h required 0", s_axi_rdata);
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid} !== 5'b11000)
      $display("FAIL reset_release: got %b required 11000",
               {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid});
    else n_pass++;
  endtask

  task automatic test_single();
    int lat, lat0, unst;
    beat_t e, o;
    logic [1:0] eb, ob;
    send_aw(32'h10, 8'd0);
    n_checks++;
    if ({s_axi_awready, s_axi_wready} !== 2'b01)
      $display("FAIL single_wdata_state: got aw/w %b required 01", {s_axi_awready, s_axi_wready});
    else n_pass++;
    exp_bq.push_back(OKAY);
    send_w(64'h1122334455667788, 8'hFF, 1'b1);
    recv_b(lat);
    n_checks++;
    if (lat !== 0) $display("FAIL single_b_latency: got %0d required 0", lat); else n_pass++;
    n_checks++;
    if (s_axi_awready !== 1'b1) $display("FAIL single_awready_after_b: got %b required 1",
                                         s_axi_awready);
    else n_pass++;
    exp_rq.push_back(mk(64'h1122334455667788, OKAY, 1'b1));
    send_ar(32'h10, 8'd0);
    recv_r(1, 4'hF, lat0, unst);
    n_checks++;
    if (lat0 !== 0) $display("FAIL single_r_latency: got %0d required 0", lat0); else n_pass++;
    n_checks++;
    if ({s_axi_arready, s_axi_rvalid} !== 2'b10)
      $display("FAIL single_arready_after_rlast: got %b required 10",
               {s_axi_arready, s_axi_rvalid});
    else n_pass++;
    while (exp_bq.size() != 0) begin
      eb = exp_bq.pop_front();
      ob = (obs_bq.size() != 0) ? obs_bq.pop_front() : 2'bxx;
      n_checks++;
      if (ob !== eb) $display("FAIL single_bresp: got %b required %b", ob, eb); else n_pass++;
    end
    while (exp_rq.size() != 0) begin
      e = exp_rq.pop_front();
      if (obs_rq.size() != 0) o = obs_rq.pop_front(); else o = 'x;
      n_checks++;
      if (o !== e) $display("FAIL single_rbeat: got %h/%b/%b required %h/%b/%b",
                            o.data, o.resp, o.last, e.data, e.resp, e.last);
      else n_pass++;
    end
  endtask

  task automatic test_byte_strobes();
    int lat, lat0, unst;
    beat_t e, o;
    send_aw(32'h18, 8'd0); send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1); recv_b(lat);
    send_aw(32'h18, 8'd0); send_w(64'h0, 8'h0F, 1'b1); recv_b(lat);
    obs_bq.delete();
    exp_rq.push_back(mk(64'hFFFF_FFFF_0000_0000, OKAY, 1'b1));
    send_ar(32'h18, 8'd0);
    recv_r(1, 4'hF, lat0, unst);
    while (exp_rq.size() != 0) begin
      e = exp_rq.pop_front();
      if (obs_rq.size() != 0) o = obs_rq.pop_front(); else o = 'x;
      n_checks++;
      if (o !== e) $display("FAIL strobe_rbeat: got %h/%b/%b required %h/%b/%b",
                            o.data, o.resp, o.last, e.data, e.resp, e.last);
      else n_pass++;
    end
  endtask

  task automatic test_burst_backpressure();
    int lat, lat0, unst;
    beat_t e, o;
    send_aw(32'h40, 8'd3);
    for (int i = 1; i <= 4; i++) send_w(64'(i), 8'hFF, (i == 4));
    recv_b(lat);
    n_checks++;
    if (lat !== 0) $display("FAIL burst_b_latency: got %0d required 0", lat); else n_pass++;
    n_checks++;
    if (obs_bq.size() != 1 || obs_bq[0] !== OKAY)
      $display("FAIL burst_bresp: got %0d responses required 1 OKAY", obs_bq.size());
    else n_pass++;
    obs_bq.delete();
    for (int i = 1; i <= 4; i++) exp_rq.push_back(mk(64'(i), OKAY, (i == 4)));
    send_ar(32'h40, 8'd3);
    recv_r(4, 4'b0101, lat0, unst);
    n_checks++;
    if (unst !== 0) $display("FAIL burst_stall_stable: got %0d changes required 0", unst);
    else n_pass++;
    while (exp_rq.size() != 0) begin
      e = exp_rq.pop_front();
      if (obs_rq.size() != 0) o = obs_rq.pop_front(); else o = 'x;
      n_checks++;
      if (o !== e) $display("FAIL burst_rbeat: got %h/%b/%b required %h/%b/%b",
                            o.data, o.resp, o.last, e.data, e.resp, e.last);
      else n_pass++;
    end
  endtask

  task automatic test_error_cases();
    int lat, lat0, unst;
    beat_t e, o;
    logic [1:0] eb, ob;
    // read just past the top of memory
    exp_rq.push_back(mk(64'h0, SLVERR, 1'b1));
    send_ar(32'h2000, 8'd0);
    recv_r(1, 4'hF, lat0, unst);
    // wlast asserted early: burst still runs two beats
    exp_bq.push_back(SLVERR);
    send_aw(32'h80, 8'd1);
    send_w(64'hAAAA_0000_0000_0001, 8'hFF, 1'b1);
    send_w(64'hBBBB_0000_0000_0002, 8'hFF, 1'b1);
    recv_b(lat);
    n_checks++;
    if (lat !== 0) $display("FAIL err_wlast_b_latency: got %0d required 0", lat); else n_pass++;
    // second beat crosses the top of memory
    exp_bq.push_back(SLVERR);
    send_aw(32'h1FF8, 8'd1);
    send_w(64'hCCCC_0000_0000_0003, 8'hFF, 1'b0);
    send_w(64'hDDDD_0000_0000_0004, 8'hFF, 1'b1);
    recv_b(lat);
    exp_rq.push_back(mk(64'hAAAA_0000_0000_0001, OKAY, 1'b0));
    exp_rq.push_back(mk(64'hBBBB_0000_0000_0002, OKAY, 1'b1));
    send_ar(32'h80, 8'd1);
    recv_r(2, 4'hF, lat0, unst);
    exp_rq.push_back(mk(64'hCCCC_0000_0000_0003, OKAY, 1'b0));
    exp_rq.push_back(mk(64'h0, SLVERR, 1'b1));
    send_ar(32'h1FF8, 8'd1);
    recv_r(2, 4'hF, lat0, unst);
    while (exp_bq.size() != 0) begin
      eb = exp_bq.pop_front();
      ob = (obs_bq.size() != 0) ? obs_bq.pop_front() : 2'bxx;
      n_checks++;
      if (ob !== eb) $display("FAIL err_bresp: got %b required %b", ob, eb); else n_pass++;
    end
    while (exp_rq.size() != 0) begin
      e = exp_rq.pop_front();
      if (obs_rq.size() != 0) o = obs_rq.pop_front(); else o = 'x;
      n_checks++;
      if (o !== e) $display("FAIL err_rbeat: got %h/%b/%b required %h/%b/%b",
                            o.data, o.resp, o.last, e.data, e.resp, e.last);
      else n_pass++;
    end
  endtask

  task automatic test_concurrent_rw();
    int lat, lat0, unst;
    beat_t e, o;
    send_aw(32'h100, 8'd0); send_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1); recv_b(lat);
    obs_bq.delete();
    send_aw(32'h100, 8'd0);
    s_axi_wdata = 64'hFEDC_BA98_7654_3210; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1;
    s_axi_wvalid = 1'b1;
    s_axi_araddr = 32'h100; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    n_checks++;
    if ({s_axi_wready, s_axi_arready} !== 2'b11)
      $display("FAIL conc_same_edge: got w/ar ready %b required 11",
               {s_axi_wready, s_axi_arready});
    else n_pass++;
    exp_rq.push_back(mk(64'h0123_4567_89AB_CDEF, OKAY, 1'b1));
    step();
    s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    recv_r(1, 4'hF, lat0, unst);
    recv_b(lat);
    exp_rq.push_back(mk(64'hFEDC_BA98_7654_3210, OKAY, 1'b1));
    send_ar(32'h100, 8'd0);
    recv_r(1, 4'hF, lat0, unst);
    n_checks++;
    if (obs_bq.size() != 1 || obs_bq[0] !== OKAY)
      $display("FAIL conc_bresp: got %0d responses required 1 OKAY", obs_bq.size());
    else n_pass++;
    obs_bq.delete();
    while (exp_rq.size() != 0) begin
      e = exp_rq.pop_front();
      if (obs_rq.size() != 0) o = obs_rq.pop_front(); else o = 'x;
      n_checks++;
      if (o !== e) $display("FAIL conc_rbeat: got %h/%b/%b required %h/%b/%b",
                            o.data, o.resp, o.last, e.data, e.resp, e.last);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int lat0, unst;
    beat_t e, o;
    send_ar(32'h40, 8'd3);
    s_axi_rready = 1'b1;
    step();
    n_checks++;
    if ({s_axi_rvalid, s_axi_rdata, s_axi_rlast} !== {1'b1, 64'd2, 1'b0})
      $display("FAIL rstmid_beat1: got %b/%h/%b required 1/2/0",
               s_axi_rvalid, s_axi_rdata, s_axi_rlast);
    else n_pass++;
    rst = 1'b1; s_axi_rready = 1'b0;
    step();
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready, s_axi_rvalid,
         s_axi_rresp, s_axi_rlast, s_axi_rdata} !== 74'b0)
      $display("FAIL rstmid_outputs: got rv=%b rd=%h rl=%b ar=%b required all 0",
               s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_arready);
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if ({s_axi_arready, s_axi_awready, s_axi_rvalid} !== 3'b110)
      $display("FAIL rstmid_release: got %b required 110",
               {s_axi_arready, s_axi_awready, s_axi_rvalid});
    else n_pass++;
    // write aborted after its first beat keeps that beat in RAM
    send_aw(32'h300, 8'd3);
    send_w(64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({s_axi_wready, s_axi_bvalid, s_axi_awready} !== 3'b001)
      $display("FAIL rstmid_wabort: got w/b/aw %b required 001",
               {s_axi_wready, s_axi_bvalid, s_axi_awready});
    else n_pass++;
    exp_rq.push_back(mk(64'd2, OKAY, 1'b1));
    send_ar(32'h48, 8'd0);
    recv_r(1, 4'hF, lat0, unst);
    exp_rq.push_back(mk(64'hA5A5_A5A5_5A5A_5A5A, OKAY, 1'b1));
    send_ar(32'h300, 8'd0);
    recv_r(1, 4'hF, lat0, unst);
    while (exp_rq.size() != 0) begin
      e = exp_rq.pop_front();
      if (obs_rq.size() != 0) o = obs_rq.pop_front(); else o = 'x;
      n_checks++;
      if (o !== e) $display("FAIL rstmid_rbeat: got %h/%b/%b required %h/%b/%b",
                            o.data, o.resp, o.last, e.data, e.resp, e.last);
      else n_pass++;
    end
    n_checks++;
    if (g_tmo) $display("FAIL handshake_timeout: got timeout required none"); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_rready = 1'b0;
    test_reset();
    test_single();
    test_byte_strobes();
    test_burst_backpressure();
    test_error_cases();
    test_concurrent_rw();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
